fu_div: RTL and testbench

//  Multi-cycle iterative integer divider FU for RV32M DIV/DIVU/REM/REMU; inverse companion of the mult FU.

---
 rtl/fu_div.sv | 169 ++++++++++++++++
 tb/tb_fu_div.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fu_div.sv
// fu_div: multi-cycle restoring divider FU for RV32M DIV/DIVU/REM/REMU.
// Retires BITS_PER_CYCLE quotient bits per DIVIDE cycle. One op is in flight
// at a time. kill squashes the op in flight.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   start                 issue request, taken only while busy==0
//   kill                  sync squash of the op in flight
//   mode[1:0]             00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   dividend, divisor     rs1/rs2, sampled on the accept edge only
//   result                quotient or remainder, valid with done, held after
//   done                  one-cycle registered completion pulse
//   busy                  high in any state other than IDLE

// One restoring step: shift {rem,quo} left by one, then trial-subtract.
// rem < dvsr on entry, so the shifted value fits in XLEN+1 bits.
module fu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvsr};
  // A clear borrow bit means the trial subtract holds.
  assign rem_nxt = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], ~diff[XLEN]};
endmodule

module fu_div #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy
);
  localparam int K     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DIVIDE, S_FIXUP} state_t;

  typedef struct packed {
    logic [1:0]      mode;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  state_t state, state_d;
  req_t req_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic q_neg_q, r_neg_q, bypass_q;

  // Operand decode for SETUP.
  logic            is_signed, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs;

  assign is_signed = ~req_q.mode[0];
  assign a_neg     = is_signed & req_q.a[XLEN-1];
  assign b_neg     = is_signed & req_q.b[XLEN-1];
  assign a_abs     = a_neg ? (~req_q.a + 1'b1) : req_q.a;
  assign b_abs     = b_neg ? (~req_q.b + 1'b1) : req_q.b;
  assign div_zero  = (req_q.b == '0);
  assign ovf       = is_signed & (req_q.a == MIN_NEG) & (&req_q.b);

  // Chain of BITS_PER_CYCLE restoring steps evaluated in one cycle.
  logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_ch, quo_ch;
  assign rem_ch[0] = rem_q;
  assign quo_ch[0] = quo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    fu_div_step #(.XLEN(XLEN)) u_step (
      .rem     (rem_ch[g]),
      .quo     (quo_ch[g]),
      .dvsr    (dvsr_q),
      .rem_nxt (rem_ch[g+1]),
      .quo_nxt (quo_ch[g+1])
    );
  end

  // Sign fixup. Special cases already hold their final values.
  logic [XLEN-1:0] quo_fix, rem_fix, sel;
  assign quo_fix = (q_neg_q & ~bypass_q) ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = (r_neg_q & ~bypass_q) ? (~rem_q + 1'b1) : rem_q;
  assign sel     = req_q.mode[1] ? rem_fix : quo_fix;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:   if (start) state_d = S_SETUP;
      S_SETUP:  state_d = (div_zero | ovf) ? S_FIXUP : S_DIVIDE;
      S_DIVIDE: if (cnt_q == '0) state_d = S_FIXUP;
      S_FIXUP:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // kill wins over everything, including a same-cycle start.
    if (kill) state_d = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      bypass_q <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!kill) begin
        case (state)
          S_IDLE: if (start) req_q <= '{mode: mode, a: dividend, b: divisor};
          S_SETUP: begin
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            bypass_q <= div_zero | ovf;
            cnt_q    <= CNT_W'(K - 1);
            rem_q    <= '0;
            dvsr_q   <= b_abs;
            if (div_zero) begin
              quo_q <= '1;
              rem_q <= req_q.a;
            end else if (ovf) begin
              quo_q <= MIN_NEG;
            end else begin
              quo_q <= a_abs;
            end
          end
          S_DIVIDE: begin
            rem_q <= rem_ch[BITS_PER_CYCLE];
            quo_q <= quo_ch[BITS_PER_CYCLE];
            cnt_q <= cnt_q - CNT_W'(1);
          end
          S_FIXUP: begin
            result <= sel;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fu_div.sv
module tb_fu_div;
  logic        clock = 1'b0;
  logic        reset;
  logic        start, kill;
  logic [1:0]  mode;
  logic [31:0] dividend, divisor;
  logic [31:0] result;
  logic        done, busy;

  fu_div #(.XLEN(32), .BITS_PER_CYCLE(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .kill     (kill),
    .mode     (mode),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic prev_done = 1'b0;
  logic [31:0] last_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest pending op.
  always @(negedge clock) begin
    if (!reset) begin
      if (prev_done) chk("done_one_cycle", {31'b0, done}, 32'd0);
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result %h with no op pending", result);
        end else begin
          mon_e = sbq.pop_front();
          chk(mon_e.name, result, mon_e.exp);
          chk({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
          chk({mon_e.name, "_busy_on_done"}, {31'b0, busy}, 32'd0);
        end
      end
    end
    prev_done = done;
  end

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d ops pending, want 0", sbq.size());
      sbq.delete();
    end
    @(negedge clock);
  endtask

  task automatic issue(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; mode = m; dividend = a; divisor = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    issue(v.mode, v.a, v.b);
    e.name = v.name; e.exp = v.exp; e.due = cyc + v.lat;
    sbq.push_back(e);
    chk({v.name, "_busy"}, {31'b0, busy}, 32'd1);
    last_exp = v.exp;
    wait_drain();
  endtask

  vec_t tv[20];

  initial begin
    exp_t e;
    int n, c1;

    tv[0]  = '{"div_100_7",     2'b00, 32'd100,      32'd7,        32'd14,       18};
    tv[1]  = '{"rem_100_7",     2'b10, 32'd100,      32'd7,        32'd2,        18};
    tv[2]  = '{"div_m7_2",      2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 18};
    tv[3]  = '{"rem_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 18};
    tv[4]  = '{"divu_max_1",    2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 18};
    tv[5]  = '{"div_5_0",       2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    tv[6]  = '{"rem_5_0",       2'b10, 32'd5,        32'd0,        32'd5,        2};
    tv[7]  = '{"remu_0_0",      2'b11, 32'd0,        32'd0,        32'd0,        2};
    tv[8]  = '{"div_ovf",       2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    tv[9]  = '{"rem_ovf",       2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};
    tv[10] = '{"divu_min_max",  2'b01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        18};
    tv[11] = '{"remu_max_16",   2'b11, 32'hFFFFFFFF, 32'd16,       32'd15,       18};
    tv[12] = '{"div_7_m2",      2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 18};
    tv[13] = '{"rem_7_m2",      2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        18};
    tv[14] = '{"div_m8_m3",     2'b00, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2,        18};
    tv[15] = '{"rem_m8_m3",     2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 18};
    tv[16] = '{"div_min_1",     2'b00, 32'h80000000, 32'd1,        32'h80000000, 18};
    tv[17] = '{"rem_m5_0",      2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 2};
    tv[18] = '{"divu_0_0",      2'b01, 32'd0,        32'd0,        32'hFFFFFFFF, 2};
    tv[19] = '{"divu_1000_33",  2'b01, 32'd1000,     32'd33,       32'd30,       18};

    reset = 1'b1; start = 1'b0; kill = 1'b0;
    mode = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(negedge clock);
    chk("reset_result", result, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) run_op(tv[i]);

    // Kill five cycles after accept: no done, result keeps the old value.
    issue(2'b00, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_result_held", result, last_exp);
    repeat (25) @(negedge clock);
    chk("kill_result_still_held", result, last_exp);
    run_op('{"divu_9_3_after_kill", 2'b01, 32'd9, 32'd3, 32'd3, 18});

    // start held high through the busy period and the done cycle.
    @(negedge clock);
    start = 1'b1; mode = 2'b00; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock);
    @(negedge clock);
    e.name = "b2b_first"; e.exp = 32'd14; e.due = cyc + 18;
    sbq.push_back(e);
    mode = 2'b01; dividend = 32'd1000; divisor = 32'd10;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b2b_done_timeout: done %b want 1", done);
    end
    c1 = cyc;
    @(negedge clock);
    start = 1'b0;
    e.name = "b2b_second"; e.exp = 32'd100; e.due = c1 + 1 + 18;
    sbq.push_back(e);
    // Start pulses with junk operands while busy must be ignored.
    repeat (3) begin
      @(negedge clock);
      start = 1'b1; mode = 2'b10; dividend = 32'd77; divisor = 32'd5;
      @(negedge clock);
      start = 1'b0;
    end
    wait_drain();

    // Async reset mid-DIVIDE clears outputs without waiting for a clock edge.
    issue(2'b00, 32'd100, 32'd7);
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("areset_result", result, 32'd0);
    chk("areset_done", {31'b0, done}, 32'd0);
    chk("areset_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    chk("areset_result_after", result, 32'd0);
    run_op('{"div_after_reset", 2'b00, 32'd100, 32'd7, 32'd14, 18});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end
endmodule
